// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading/trailing zero counter and normaliser.
//
// Stage 1 bit-reverses the operand for trailing-zero mode, then registers a 2-bit zero count and
// an all-zero flag for each nibble. Stage 2 merges the nibble counts and shifts the operand.
// The result appears two cycles after acceptance. Stalls from out_ready_i propagate back to
// in_ready_o combinationally.
//
// Ports
//   clk_i, rst_i       clock (rising edge); asynchronous active-high reset
//   flush_i            synchronous flush; empties both stages, overrides the handshake
//   in_valid_i/_ready_o  input handshake
//   in_data_i          operand, WIDTH bits
//   in_mode_i          0 = leading-zero count, 1 = trailing-zero count
//   in_tag_i           sideband tag, carried unchanged with the operand
//   out_valid_o/out_ready_i  output handshake
//   out_count_o        zero count, 0..WIDTH
//   out_all_zero_o     operand was all zeros
//   out_norm_o         operand shifted so that the first one lands on the counted end
//   out_mode_o, out_tag_o  mode and tag of this result
module lzc_norm_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CW   = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_mode_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    out_count_o,
  output logic             out_all_zero_o,
  output logic [WIDTH-1:0] out_norm_o,
  output logic             out_mode_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int unsigned NumNib = WIDTH / 4;

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s1_en, s2_en;

  assign s2_en      = ~out_valid_q | out_ready_i;
  assign s1_en      = ~s1_valid_q | s2_en;
  assign in_ready_o = s1_en;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_en) s1_valid_d = in_valid_i;
    if (s2_en) out_valid_d = s1_valid_q;
    if (flush_i) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // Stage 1: orient the operand so the counted end is always the MSB, then count per nibble.
  // Nibble 0 is the most significant nibble of the oriented operand.
  logic [WIDTH-1:0]           d_c;
  logic [NumNib-1:0][1:0]     nib_cnt_c;
  logic [NumNib-1:0]          nib_zero_c;

  always_comb begin
    d_c        = '0;
    nib_cnt_c  = '0;
    nib_zero_c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      d_c[b] = in_mode_i ? in_data_i[WIDTH-1-b] : in_data_i[b];
    end
    for (int j = 0; j < NumNib; j++) begin
      logic [3:0] nib;
      nib           = d_c[WIDTH-1-4*j -: 4];
      nib_zero_c[j] = (nib == 4'b0000);
      if (nib[3])      nib_cnt_c[j] = 2'd0;
      else if (nib[2]) nib_cnt_c[j] = 2'd1;
      else if (nib[1]) nib_cnt_c[j] = 2'd2;
      else             nib_cnt_c[j] = 2'd3;
    end
  end

  logic [WIDTH-1:0]       d_q, data_q;
  logic [NumNib-1:0][1:0] nib_cnt_q;
  logic [NumNib-1:0]      nib_zero_q;
  logic                   mode_q;
  logic [TAG_W-1:0]       tag_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      d_q        <= '0;
      data_q     <= '0;
      nib_cnt_q  <= '0;
      nib_zero_q <= '0;
      mode_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_en) begin
        d_q        <= d_c;
        data_q     <= in_data_i;
        nib_cnt_q  <= nib_cnt_c;
        nib_zero_q <= nib_zero_c;
        mode_q     <= in_mode_i;
        tag_q      <= in_tag_i;
      end
    end
  end

  // Stage 2: the first non-zero nibble decides the count. Scanning from the far end lets the
  // lowest index win.
  logic [CW-1:0]    count_c;
  logic             all_zero_c;
  logic [WIDTH-1:0] norm_c;

  always_comb begin
    count_c = CW'(WIDTH);
    for (int j = NumNib - 1; j >= 0; j--) begin
      if (!nib_zero_q[j]) count_c = CW'(4 * j) + CW'(nib_cnt_q[j]);
    end
    all_zero_c = ~|d_q;
    if (all_zero_c)  norm_c = '0;
    else if (mode_q) norm_c = data_q >> count_c;
    else             norm_c = data_q << count_c;
  end

  logic [CW-1:0]    count_q;
  logic             all_zero_q;
  logic [WIDTH-1:0] norm_q;
  logic             omode_q;
  logic [TAG_W-1:0] otag_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      count_q     <= '0;
      all_zero_q  <= 1'b0;
      norm_q      <= '0;
      omode_q     <= 1'b0;
      otag_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_en) begin
        count_q    <= count_c;
        all_zero_q <= all_zero_c;
        norm_q     <= norm_c;
        omode_q    <= mode_q;
        otag_q     <= tag_q;
      end
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_count_o    = count_q;
  assign out_all_zero_o = all_zero_q;
  assign out_norm_o     = norm_q;
  assign out_mode_o     = omode_q;
  assign out_tag_o      = otag_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
module tb_lzc_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic        out_all_zero, out_mode;
  logic [31:0] in_data, out_norm;
  logic [3:0]  in_tag, out_tag;
  logic [5:0]  out_count;

  lzc_norm_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_mode_i(in_mode), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_count_o(out_count),
    .out_all_zero_o(out_all_zero), .out_norm_o(out_norm), .out_mode_o(out_mode),
    .out_tag_o(out_tag)
  );

  // Narrow and wide instances for the single-bit walk.
  logic        sw_flush = 1'b0, sw_ready = 1'b1;
  logic [3:0]  sw_tag = 4'h0;
  logic        v8_in, m8, r8, v8, az8, om8;
  logic [7:0]  d8, n8;
  logic [3:0]  c8, t8;
  logic        v64_in, m64, r64, v64, az64, om64;
  logic [63:0] d64, n64;
  logic [6:0]  c64;
  logic [3:0]  t64;

  lzc_norm_pipe #(.WIDTH(8), .TAG_W(4)) u_w8 (
    .clk_i(clk), .rst_i(rst), .flush_i(sw_flush),
    .in_valid_i(v8_in), .in_ready_o(r8), .in_data_i(d8), .in_mode_i(m8), .in_tag_i(sw_tag),
    .out_valid_o(v8), .out_ready_i(sw_ready), .out_count_o(c8), .out_all_zero_o(az8),
    .out_norm_o(n8), .out_mode_o(om8), .out_tag_o(t8)
  );

  lzc_norm_pipe #(.WIDTH(64), .TAG_W(4)) u_w64 (
    .clk_i(clk), .rst_i(rst), .flush_i(sw_flush),
    .in_valid_i(v64_in), .in_ready_o(r64), .in_data_i(d64), .in_mode_i(m64), .in_tag_i(sw_tag),
    .out_valid_o(v64), .out_ready_i(sw_ready), .out_count_o(c64), .out_all_zero_o(az64),
    .out_norm_o(n64), .out_mode_o(om64), .out_tag_o(t64)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand through an idle pipe; checks latency and every output field.
  task automatic run_one(input string name, input logic [31:0] data, input logic mode,
                         input logic [3:0] tag, input int exp_cnt, input logic exp_az,
                         input logic [31:0] exp_norm);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    in_tag   = tag;
    #1;
    chk({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({name, "_early"}, out_valid, 0);
    tick();
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_count"}, out_count, exp_cnt);
    chk({name, "_all_zero"}, out_all_zero, exp_az);
    chk({name, "_norm"}, out_norm, exp_norm);
    chk({name, "_mode"}, out_mode, mode);
    chk({name, "_tag"}, out_tag, tag);
    tick();
  endtask

  logic [31:0] s_data [8];
  logic        s_mode [8];
  int          s_cnt  [8];
  logic [31:0] s_norm [8];

  initial begin
    int  sent, rcv, cyc;
    logic acc, fire;

    s_data[0] = 32'h0000_0001; s_mode[0] = 0; s_cnt[0] = 31; s_norm[0] = 32'h8000_0000;
    s_data[1] = 32'h0000_0001; s_mode[1] = 1; s_cnt[1] = 0;  s_norm[1] = 32'h0000_0001;
    s_data[2] = 32'h0001_0000; s_mode[2] = 0; s_cnt[2] = 15; s_norm[2] = 32'h8000_0000;
    s_data[3] = 32'h0001_0000; s_mode[3] = 1; s_cnt[3] = 16; s_norm[3] = 32'h0000_0001;
    s_data[4] = 32'h0F00_0000; s_mode[4] = 0; s_cnt[4] = 4;  s_norm[4] = 32'hF000_0000;
    s_data[5] = 32'h0F00_0000; s_mode[5] = 1; s_cnt[5] = 24; s_norm[5] = 32'h0000_000F;
    s_data[6] = 32'h0000_0000; s_mode[6] = 1; s_cnt[6] = 32; s_norm[6] = 32'h0000_0000;
    s_data[7] = 32'h1234_5678; s_mode[7] = 0; s_cnt[7] = 3;  s_norm[7] = 32'h91A2_B3C0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    v8_in = 1'b0; d8 = '0; m8 = 1'b0; v64_in = 1'b0; d64 = '0; m64 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_all_zero", out_all_zero, 0);
    chk("rst_norm", out_norm, 0);
    chk("rst_mode", out_mode, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    run_one("lz_1000",   32'h0000_1000, 0, 4'h1, 19, 0, 32'h8000_0000);
    run_one("tz_1000",   32'h0000_1000, 1, 4'h2, 12, 0, 32'h0000_0001);
    run_one("tz_msb",    32'h8000_0000, 1, 4'h3, 31, 0, 32'h0000_0001);
    run_one("lz_zero",   32'h0000_0000, 0, 4'h4, 32, 1, 32'h0000_0000);
    run_one("tz_zero",   32'h0000_0000, 1, 4'h5, 32, 1, 32'h0000_0000);
    run_one("lz_ones",   32'hFFFF_FFFF, 0, 4'h6, 0,  0, 32'hFFFF_FFFF);
    run_one("tz_ones",   32'hFFFF_FFFF, 1, 4'h7, 0,  0, 32'hFFFF_FFFF);
    run_one("lz_00f0",   32'h00F0_0000, 0, 4'h8, 8,  0, 32'hF000_0000);
    run_one("tz_00f0",   32'h00F0_0000, 1, 4'h9, 20, 0, 32'h0000_000F);
    run_one("tz_mixed",  32'h1234_5678, 1, 4'hA, 3,  0, 32'h0246_8ACF);

    // Back-to-back stream with a three-cycle output stall; every valid cycle is checked against
    // the next expected result, so held outputs are checked too.
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = s_data[sent];
        in_mode = s_mode[sent];
        in_tag  = sent[3:0];
      end
      #1;
      if (cyc >= 3 && cyc <= 5) chk("stall_in_ready", in_ready, 0);
      if (cyc == 6) chk("resume_in_ready", in_ready, 1);
      if (out_valid) begin
        chk("stream_tag", out_tag, rcv);
        chk("stream_count", out_count, s_cnt[rcv]);
        chk("stream_norm", out_norm, s_norm[rcv]);
        chk("stream_mode", out_mode, s_mode[rcv]);
      end
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      tick();
      if (acc) sent++;
      if (fire) rcv++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_all_out", rcv, 8);

    // Flush with two operands in flight and a third presented; none may be handed over.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h0000_0100; in_tag = 4'hA;
    tick();
    in_data = 32'h0000_0200; in_tag = 4'hB;
    tick();
    in_data = 32'h0000_0400; in_tag = 4'hC; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("flush_out_valid", out_valid, 0);
      tick();
    end

    // Flush beats acceptance even when the pipe is empty and ready.
    in_valid = 1'b1; in_data = 32'h0000_0800; in_tag = 4'hD; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_drop", out_valid, 0);
      tick();
    end
    run_one("post_flush", 32'h0000_0010, 0, 4'hE, 27, 0, 32'h8000_0000);

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1; in_data = 32'h0000_1000; in_mode = 1'b0; in_tag = 4'h5;
    tick();
    in_tag = 4'h6;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", out_count, 0);
    chk("async_rst_norm", out_norm, 0);
    chk("async_rst_tag", out_tag, 0);
    chk("async_rst_all_zero", out_all_zero, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", out_valid, 0);
    run_one("post_rst", 32'h0000_1000, 1, 4'h7, 12, 0, 32'h0000_0001);

    // Single-bit walk on the 8- and 64-bit instances.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        d64 = 64'd1 << i; m64 = m[0]; v64_in = 1'b1;
        if (i < 8) begin
          d8 = 8'd1 << i; m8 = m[0]; v8_in = 1'b1;
        end
        tick();
        v64_in = 1'b0; v8_in = 1'b0;
        tick();
        chk("w64_valid", v64, 1);
        chk("w64_count", c64, (m == 1) ? i : 63 - i);
        chk("w64_norm", n64, (m == 1) ? 64'd1 : 64'h8000_0000_0000_0000);
        if (i < 8) begin
          chk("w8_valid", v8, 1);
          chk("w8_count", c8, (m == 1) ? i : 7 - i);
          chk("w8_norm", n8, (m == 1) ? 8'h01 : 8'h80);
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
